// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the flop-based threshold FIFO.
//   fifo_op_e : request decoded from {push, pop}
//   cnt_w()   : width of an occupancy counter able to hold 0..depth
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    POP      = 2'b01,
    PUSH     = 2'b10,
    PUSH_POP = 2'b11
  } fifo_op_e;

  // Occupancy runs from 0 to depth inclusive, hence depth+1 values
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// ---------------------------------------------------------------------------
// fifo_ptr
// Wrapping read/write pointer for a circular buffer of any depth >= 2.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, pointer returns to 0
//   i_inc  in   advance the pointer by one this cycle
//   o_ptr  out  current pointer value, 0..depth-1
// ---------------------------------------------------------------------------
module fifo_ptr #(
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_inc,
  output logic [$clog2(depth)-1:0] o_ptr
);

  localparam int PW = $clog2(depth);

  logic [PW-1:0] r_ptr;

  // Explicit wrap at depth-1 so non-power-of-two depths work
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      if (r_ptr == PW'(depth - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= r_ptr + PW'(1);
      end
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_flops_thr.sv
// ---------------------------------------------------------------------------
// fifo_flops_thr
// Flop-based synchronous FIFO built as a circular buffer with wrapping
// read/write pointers, an occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.  FWFT=1 shows the head
// word on Dout combinationally; FWFT=0 registers Dout on each accepted pop.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   Din, push     write data and write request
//   pop           read request
//   clr_err       clears the sticky error flags
//   Dout          read data
//   full, pndng   count == depth / count != 0
//   almost_full   count >= depth-AF_MARGIN
//   almost_empty  count <= AE_MARGIN
//   count         current occupancy
//   overflow      sticky: push while full with no pop
//   underflow     sticky: pop while empty
// ---------------------------------------------------------------------------
module fifo_flops_thr
  import fifo_pkg::*;
#(
  parameter int depth     = 16,
  parameter int bits      = 32,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  parameter int FWFT      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [bits-1:0]           Din,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      clr_err,
  output logic [bits-1:0]           Dout,
  output logic                      full,
  output logic                      pndng,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(depth)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CW = cnt_w(depth);
  localparam int PW = $clog2(depth);

  logic [bits-1:0] r_mem [depth];
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_underflow;

  logic [PW-1:0]   w_wrPtr;
  logic [PW-1:0]   w_rdPtr;
  fifo_op_e        w_op;
  logic            w_pushAcc;
  logic            w_popAcc;
  logic            w_pushErr;
  logic            w_popErr;

  assign w_op = fifo_op_e'({push, pop});

  // Accept decisions.  A pop is only honoured when data was already stored,
  // so a same-cycle push never satisfies a pop on an empty FIFO.  A push
  // into a full FIFO is allowed only when the pop frees a slot this cycle.
  always_comb begin
    w_pushAcc = 1'b0;
    w_popAcc  = 1'b0;
    w_pushErr = 1'b0;
    w_popErr  = 1'b0;
    case (w_op)
      PUSH: begin
        w_pushAcc = !full;
        w_pushErr = full;
      end
      POP: begin
        w_popAcc = pndng;
        w_popErr = !pndng;
      end
      PUSH_POP: begin
        w_popAcc  = pndng;
        w_popErr  = !pndng;
        w_pushAcc = !full || pndng;
        w_pushErr = full && !pndng;
      end
      default: begin
      end
    endcase
  end

  fifo_ptr #(.depth(depth)) u_wrPtr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_pushAcc),
    .o_ptr (w_wrPtr)
  );

  fifo_ptr #(.depth(depth)) u_rdPtr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_popAcc),
    .o_ptr (w_rdPtr)
  );

  // Storage is cleared on reset so Dout reads 0 afterwards in FWFT mode
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_pushAcc) begin
      r_mem[w_wrPtr] <= Din;
    end
  end

  // Occupancy only moves when exactly one side is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_pushAcc && !w_popAcc) begin
      r_count <= r_count + CW'(1);
    end else if (w_popAcc && !w_pushAcc) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pushErr) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_popErr) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign count        = r_count;
  assign full         = (r_count == CW'(depth));
  assign pndng        = (r_count != '0);
  assign almost_full  = (r_count >= CW'(depth - AF_MARGIN));
  assign almost_empty = (r_count <= CW'(AE_MARGIN));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  generate
    if (FWFT != 0) begin : g_fwft
      assign Dout = r_mem[w_rdPtr];
    end else begin : g_regRead
      logic [bits-1:0] r_dout;

      // Registered read: Dout takes the head word on an accepted pop only
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout <= '0;
        end else if (w_popAcc) begin
          r_dout <= r_mem[w_rdPtr];
        end
      end

      assign Dout = r_dout;
    end
  endgenerate

endmodule
